// File: rtl/hazard_ctrl_param_if.sv
// Decode/execute hazard interface: decode-side instruction info in, interlock status out.
interface hazard_ctrl_param_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
);
  logic             de_valid;
  logic [RA_W-1:0]  de_rs;
  logic [RA_W-1:0]  de_rt;
  logic             de_use_rs;
  logic             de_use_rt;
  logic             de_is_load;
  logic [RA_W-1:0]  de_dst;
  logic             de_is_br;
  logic             exe_allowin;
  logic             flush;
  logic             stall;
  logic             de_allowin;
  logic             issue;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: presents the decode instruction and reads back the interlock decision.
  modport master (
    output de_valid, de_rs, de_rt, de_use_rs, de_use_rt, de_is_load, de_dst,
           de_is_br, exe_allowin, flush,
    input  stall, de_allowin, issue, stall_cnt
  );

  // Hazard unit side.
  modport slave (
    input  de_valid, de_rs, de_rt, de_use_rs, de_use_rt, de_is_load, de_dst,
           de_is_br, exe_allowin, flush,
    output stall, de_allowin, issue, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_param.sv
// Parametrised decode/execute interlock: load-destination scoreboard, branch stall
// counter, valid/allowin handshake toward execute and a saturating stall-cycle counter.
module hazard_ctrl_param #(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_STALL = 3,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  hazard_ctrl_param_if.slave hz
);

  // A zero-length branch stall still needs a one-bit counter; it simply never leaves 0.
  localparam int BR_W = (BR_STALL > 0) ? $clog2(BR_STALL + 1) : 1;
  localparam logic [BR_W-1:0] BR_RELOAD = BR_W'(BR_STALL);

  logic [RA_W-1:0]  sb_q [LOAD_LAT];
  logic [RA_W-1:0]  sb_d [LOAD_LAT];
  logic [BR_W-1:0]  br_cnt_q;
  logic [BR_W-1:0]  br_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic lu_hit;
  logic br_stall;
  logic stall;
  logic de_allowin;
  logic issue;

  // Load-use hit: a read source matches a non-zero in-flight load destination.
  always_comb begin
    lu_hit = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sb_q[i] != '0) begin
        if ((hz.de_use_rs && (hz.de_rs == sb_q[i])) ||
            (hz.de_use_rt && (hz.de_rt == sb_q[i]))) begin
          lu_hit = 1'b1;
        end
      end
    end
    lu_hit = lu_hit & hz.de_valid;
  end

  assign br_stall   = (br_cnt_q != '0);
  assign stall      = lu_hit | br_stall;
  assign de_allowin = hz.exe_allowin & ~stall;
  assign issue      = hz.de_valid & de_allowin;

  // Scoreboard next state: shift only when execute advances; flush empties every stage.
  always_comb begin
    sb_d = sb_q;
    if (hz.flush) begin
      for (int i = 0; i < LOAD_LAT; i++) begin
        sb_d[i] = '0;
      end
    end else if (hz.exe_allowin) begin
      sb_d[0] = (issue && hz.de_is_load) ? hz.de_dst : '0;
      for (int i = 1; i < LOAD_LAT; i++) begin
        sb_d[i] = sb_q[i-1];
      end
    end
  end

  // Branch stall counter: reload on branch issue, otherwise count down every cycle.
  always_comb begin
    br_cnt_d = br_cnt_q;
    if (hz.flush) begin
      br_cnt_d = '0;
    end else if (issue && hz.de_is_br) begin
      br_cnt_d = BR_RELOAD;
    end else if (br_cnt_q != '0) begin
      br_cnt_d = br_cnt_q - 1'b1;
    end
  end

  // Stall-cycle counter: counts held valid instructions, sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hz.de_valid && stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < LOAD_LAT; i++) begin
        sb_q[i] <= '0;
      end
      br_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < LOAD_LAT; i++) begin
        sb_q[i] <= sb_d[i];
      end
      br_cnt_q    <= br_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall      = stall;
  assign hz.de_allowin = de_allowin;
  assign hz.issue      = issue;
  assign hz.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Bench for hazard_ctrl_param: two differently parametrised instances share one
// stimulus stream and are compared every cycle against a list-of-pending-loads model.
module tb_hazard_ctrl_param;

  localparam int LAT_A = 2;
  localparam int BRS_A = 3;
  localparam int CW_A  = 4;
  localparam int LAT_B = 1;
  localparam int BRS_B = 0;
  localparam int CW_B  = 32;

  logic clk;
  logic resetn;

  hazard_ctrl_param_if #(.RA_W(5), .CNT_W(CW_A)) ifA();
  hazard_ctrl_param_if #(.RA_W(5), .CNT_W(CW_B)) ifB();

  hazard_ctrl_param #(.RA_W(5), .LOAD_LAT(LAT_A), .BR_STALL(BRS_A), .CNT_W(CW_A)) dutA (
    .clk(clk), .resetn(resetn), .hz(ifA)
  );
  hazard_ctrl_param #(.RA_W(5), .LOAD_LAT(LAT_B), .BR_STALL(BRS_B), .CNT_W(CW_B)) dutB (
    .clk(clk), .resetn(resetn), .hz(ifB)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Current stimulus (shared by both instances).
  logic       vV, vUrs, vUrt, vLd, vBr, vExe, vFl, vRn;
  logic [4:0] vRs, vRt, vDst;

  // Reference model: outstanding loads with the number of execute advances they still need.
  int     pendDst  [2][8];
  int     pendLeft [2][8];
  int     brLeft   [2];
  longint stallCount [2];

  function automatic int latOf(int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic int brsOf(int k);
    return (k == 0) ? BRS_A : BRS_B;
  endfunction

  function automatic longint maxOf(int k);
    return (k == 0) ? ((64'd1 << CW_A) - 1) : ((64'd1 << CW_B) - 1);
  endfunction

  function automatic bit modelHit(int k);
    if (!vV) return 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (pendLeft[k][j] > 0) begin
        if ((vUrs && int'(vRs) == pendDst[k][j]) || (vUrt && int'(vRt) == pendDst[k][j]))
          return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit modelStall(int k);
    return modelHit(k) || (brLeft[k] > 0);
  endfunction

  task automatic resetModel();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 8; j++) begin
        pendDst[k][j]  = 0;
        pendLeft[k][j] = 0;
      end
      brLeft[k]     = 0;
      stallCount[k] = 0;
    end
  endtask

  task automatic updateModel(int k);
    bit st;
    bit iss;
    bit placed;
    st  = modelStall(k);
    iss = vV && vExe && !st;
    if (!vRn) begin
      for (int j = 0; j < 8; j++) pendLeft[k][j] = 0;
      brLeft[k]     = 0;
      stallCount[k] = 0;
      return;
    end
    if (vV && st && stallCount[k] < maxOf(k)) stallCount[k] = stallCount[k] + 1;
    if (vFl) begin
      for (int j = 0; j < 8; j++) pendLeft[k][j] = 0;
      brLeft[k] = 0;
    end else begin
      if (vExe) begin
        for (int j = 0; j < 8; j++)
          if (pendLeft[k][j] > 0) pendLeft[k][j] = pendLeft[k][j] - 1;
        if (iss && vLd && vDst != 5'd0) begin
          placed = 1'b0;
          for (int j = 0; j < 8; j++) begin
            if (!placed && pendLeft[k][j] == 0) begin
              pendDst[k][j]  = int'(vDst);
              pendLeft[k][j] = latOf(k);
              placed = 1'b1;
            end
          end
        end
      end
      if (iss && vBr) brLeft[k] = brsOf(k);
      else if (brLeft[k] > 0) brLeft[k] = brLeft[k] - 1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic compareInst(input string p, input int k, input logic st, input logic al,
                             input logic is, input logic [31:0] cnt);
    bit es;
    es = modelStall(k);
    checkOutput({p, ".stall"},      32'(st),  32'(es));
    checkOutput({p, ".de_allowin"}, 32'(al),  32'(vExe && !es));
    checkOutput({p, ".issue"},      32'(is),  32'(vV && vExe && !es));
    checkOutput({p, ".stall_cnt"},  cnt,      32'(stallCount[k]));
  endtask

  // Drive one cycle of inputs and compare both instances against the model at negedge.
  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic ld,
                               input logic [4:0] dst, input logic br, input logic exe,
                               input logic fl, input logic rn);
    vV = v; vRs = rs; vRt = rt; vUrs = urs; vUrt = urt; vLd = ld; vDst = dst;
    vBr = br; vExe = exe; vFl = fl; vRn = rn;
    ifA.de_valid = v; ifA.de_rs = rs; ifA.de_rt = rt; ifA.de_use_rs = urs;
    ifA.de_use_rt = urt; ifA.de_is_load = ld; ifA.de_dst = dst; ifA.de_is_br = br;
    ifA.exe_allowin = exe; ifA.flush = fl;
    ifB.de_valid = v; ifB.de_rs = rs; ifB.de_rt = rt; ifB.de_use_rs = urs;
    ifB.de_use_rt = urt; ifB.de_is_load = ld; ifB.de_dst = dst; ifB.de_is_br = br;
    ifB.exe_allowin = exe; ifB.flush = fl;
    resetn = rn;
    @(negedge clk);
    compareInst("A", 0, ifA.stall, ifA.de_allowin, ifA.issue, 32'(ifA.stall_cnt));
    compareInst("B", 1, ifB.stall, ifB.de_allowin, ifB.issue, 32'(ifB.stall_cnt));
  endtask

  task automatic finishCycle();
    updateModel(0);
    updateModel(1);
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic fl = 1'b0, input logic rn = 1'b1);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, fl, rn);
    finishCycle();
  endtask

  task automatic branch();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    finishCycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetModel();
    vV = 0; vRs = 0; vRt = 0; vUrs = 0; vUrt = 0; vLd = 0; vDst = 0;
    vBr = 0; vExe = 1; vFl = 0; vRn = 0;
    ifA.de_valid = 0; ifA.de_rs = 0; ifA.de_rt = 0; ifA.de_use_rs = 0; ifA.de_use_rt = 0;
    ifA.de_is_load = 0; ifA.de_dst = 0; ifA.de_is_br = 0; ifA.exe_allowin = 1; ifA.flush = 0;
    ifB.de_valid = 0; ifB.de_rs = 0; ifB.de_rt = 0; ifB.de_use_rs = 0; ifB.de_use_rt = 0;
    ifB.de_is_load = 0; ifB.de_dst = 0; ifB.de_is_br = 0; ifB.exe_allowin = 1; ifB.flush = 0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset released, starting directed sequence");

    // lw $5, then addu reading $5: B stalls 1 cycle, A stalls 2.
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 1, 5'd5, 0, 1, 0, 1);
    checkOutput("A.stall_after_reset", 32'(ifA.stall), 32'd0);
    checkOutput("A.cnt_after_reset", 32'(ifA.stall_cnt), 32'd0);
    checkOutput("A.lw_issue", 32'(ifA.issue), 32'd1);
    finishCycle();
    applyStimulus(1, 5'd5, 5'd0, 1, 0, 0, 5'd3, 0, 1, 0, 1);
    checkOutput("B.lu_stall", 32'(ifB.stall), 32'd1);
    checkOutput("A.lu_stall", 32'(ifA.stall), 32'd1);
    finishCycle();
    applyStimulus(1, 5'd5, 5'd0, 1, 0, 0, 5'd3, 0, 1, 0, 1);
    checkOutput("B.lu_release", 32'(ifB.issue), 32'd1);
    checkOutput("A.lu_second", 32'(ifA.stall), 32'd1);
    finishCycle();
    applyStimulus(1, 5'd5, 5'd0, 1, 0, 0, 5'd3, 0, 1, 0, 1);
    checkOutput("A.lu_release", 32'(ifA.issue), 32'd1);
    finishCycle();

    // Branch: A stalls exactly 3 cycles, B never.
    branch();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1);
      checkOutput("A.br_stall", 32'(ifA.stall), 32'd1);
      checkOutput("A.br_allowin", 32'(ifA.de_allowin), 32'd0);
      checkOutput("B.br_nostall", 32'(ifB.stall), 32'd0);
      finishCycle();
    end
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1);
    checkOutput("A.br_done", 32'(ifA.stall), 32'd0);
    checkOutput("A.cnt_5", 32'(ifA.stall_cnt), 32'd5);
    checkOutput("B.cnt_1", 32'(ifB.stall_cnt), 32'd1);
    finishCycle();

    // lw $0 never creates a hazard; an unused matching source does not either.
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 1, 0, 1);
    finishCycle();
    applyStimulus(1, 5'd0, 5'd0, 1, 1, 0, 5'd1, 0, 1, 0, 1);
    checkOutput("A.r0_nostall", 32'(ifA.stall), 32'd0);
    finishCycle();
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 1, 5'd4, 0, 1, 0, 1);
    finishCycle();
    applyStimulus(1, 5'd4, 5'd0, 0, 0, 0, 5'd1, 0, 1, 0, 1);
    checkOutput("A.unused_rs", 32'(ifA.stall), 32'd0);
    finishCycle();
    nop(); nop();

    // Load issued together with flush is not recorded.
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 0, 1, 1, 1);
    finishCycle();
    applyStimulus(1, 5'd9, 5'd0, 1, 0, 0, 5'd1, 0, 1, 0, 1);
    checkOutput("A.flush_load", 32'(ifA.stall), 32'd0);
    checkOutput("B.flush_load", 32'(ifB.stall), 32'd0);
    finishCycle();

    // lw $7 then rt=$7 consumer with execute blocked for 3 cycles: A stalls 5, B 4.
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 0, 1, 0, 1);
    finishCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 5'd0, 5'd7, 0, 1, 0, 5'd2, 0, 0, 0, 1);
      checkOutput("A.hold_stall", 32'(ifA.stall), 32'd1);
      finishCycle();
    end
    applyStimulus(1, 5'd0, 5'd7, 0, 1, 0, 5'd2, 0, 1, 0, 1);
    checkOutput("B.hold_last", 32'(ifB.stall), 32'd1);
    finishCycle();
    applyStimulus(1, 5'd0, 5'd7, 0, 1, 0, 5'd2, 0, 1, 0, 1);
    checkOutput("A.hold_last", 32'(ifA.stall), 32'd1);
    checkOutput("B.hold_issue", 32'(ifB.issue), 32'd1);
    finishCycle();
    applyStimulus(1, 5'd0, 5'd7, 0, 1, 0, 5'd2, 0, 1, 0, 1);
    checkOutput("A.hold_issue", 32'(ifA.issue), 32'd1);
    finishCycle();

    // Flush with br_cnt=2 ends the branch stall.
    branch();
    nop();
    nop(1'b1);
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1);
    checkOutput("A.flush_br", 32'(ifA.stall), 32'd0);
    finishCycle();

    // Reset mid branch stall clears stall and counter.
    branch();
    nop();
    nop(1'b0, 1'b0);
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1);
    checkOutput("A.reset_br", 32'(ifA.stall), 32'd0);
    checkOutput("A.reset_cnt", 32'(ifA.stall_cnt), 32'd0);
    finishCycle();

    // 18 branch-stall cycles saturate the 4-bit counter of A.
    for (int r = 0; r < 6; r++) begin
      branch();
      nop(); nop(); nop();
    end
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1);
    checkOutput("A.cnt_sat", 32'(ifA.stall_cnt), 32'hF);
    checkOutput("B.cnt_zero", 32'(ifB.stall_cnt), 32'd0);
    finishCycle();

    // Randomized traffic with small register range to provoke hazards.
    $display("[TB] starting random sequence");
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 7) != 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 63) != 0));
      finishCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
